// File: rtl/uart_pkg.sv
// Shared UART constants, defaults and timeout FSM encoding.
// Imported by the receive controller and its FIFO.
package uart_pkg;

    localparam int WORD_SIZE  = 8;
    localparam int CLOCK_FREQ = 72_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int BAUD_LIMIT = CLOCK_FREQ / BAUD_RATE;

    localparam int FIFO_DEPTH    = 8;
    localparam int IRQ_THRESHOLD = 4;
    // Four word-times of line idle (20000 clk at these rates).
    localparam int TIMEOUT_CYCLES = 4 * WORD_SIZE * BAUD_LIMIT;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_ARMED   = 2'd1,
        T_EXPIRED = 2'd2
    } t_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
// Ports: clk, rst, push/wdata, pop, flush, rdata (head), count,
//        count_next (post-edge occupancy), full, empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    // Head is forced to zero while empty so reset presents out_data = 0.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push & ~do_pop)
            count_next = count + 1'b1;
        else if (do_pop & ~do_push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers received words, overrun, irq.
// Ports: rx_avbl_i/rx_data in; out_data/out_valid/out_ready out;
//        enable, flush, clr_overrun; fifo_count, overrun,
//        rx_timeout, irq status. Macro UART_RX_TIMEOUT_EN builds
//        the idle-timeout FSM; otherwise rx_timeout is 0.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WORD_SIZE      = uart_pkg::WORD_SIZE,
    parameter int FIFO_DEPTH     = uart_pkg::FIFO_DEPTH,
    parameter int IRQ_THRESHOLD  = uart_pkg::IRQ_THRESHOLD,
    parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_avbl_i,
    input  logic [WORD_SIZE-1:0] rx_data,
    input  logic                 enable,
    input  logic                 flush,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        fifo_count,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 rx_timeout,
    output logic                 irq
);

    logic          push_req;
    logic          pop;
    logic          full;
    logic          empty;
    logic          drop;
    logic          overrun_next;
    logic          timeout_next;
    logic          irq_next;
    logic [CW-1:0] count_next;

    assign push_req  = rx_avbl_i & enable;
    assign out_valid = ~empty;
    assign pop       = ~empty & out_ready;

    // A full FIFO still accepts when the head leaves this cycle.
    assign drop = push_req & full & ~pop & ~flush;

    assign overrun_next = drop | (overrun & ~clr_overrun);

    uart_rx_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_req),
        .wdata      (rx_data),
        .pop        (pop),
        .flush      (flush),
        .rdata      (out_data),
        .count      (fifo_count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    t_state_e      state;
    t_state_e      state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          active;
    logic          drain;

    assign active = ((push_req & (~full | pop)) | pop) & ~flush;
    assign drain  = (count_next == '0);

    always_comb begin
        state_next = state;
        timer_next = timer;
        unique case (state)
            T_IDLE: begin
                timer_next = '0;
                if (!drain)
                    state_next = T_ARMED;
            end
            T_ARMED: begin
                if (drain) begin
                    state_next = T_IDLE;
                    timer_next = '0;
                end else if (active) begin
                    timer_next = '0;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = T_EXPIRED;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            T_EXPIRED: begin
                if (active | drain) begin
                    timer_next = '0;
                    state_next = drain ? T_IDLE : T_ARMED;
                end
            end
            default: begin
                state_next = T_IDLE;
                timer_next = '0;
            end
        endcase
        if (flush) begin
            state_next = T_IDLE;
            timer_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    assign timeout_next = (state_next == T_EXPIRED);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_next = 1'b0;
`endif

    // irq is built from next-state values so it rises with its cause.
    assign irq_next = (count_next >= CW'(IRQ_THRESHOLD))
                    | overrun_next | timeout_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun    <= 1'b0;
            rx_timeout <= 1'b0;
            irq        <= 1'b0;
        end else begin
            overrun    <= overrun_next;
            rx_timeout <= timeout_next;
            irq        <= irq_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl (depth 8, threshold 4,
// timeout 16). Timeout checks follow UART_RX_TIMEOUT_EN.
module tb_uart_rx_ctrl;

    localparam int FD = 8;
    localparam int TH = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_avbl_i = 1'b0;
    logic [7:0] rx_data = '0;
    logic       enable = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] fifo_count;
    logic       overrun;
    logic       clr_overrun = 1'b0;
    logic       rx_timeout;
    logic       irq;

    int total = 0;
    int bad = 0;
    int m_cnt = 0;
    logic [7:0] sb[$];

    uart_rx_ctrl #(
        .WORD_SIZE      (8),
        .FIFO_DEPTH     (FD),
        .IRQ_THRESHOLD  (TH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_avbl_i   (rx_avbl_i),
        .rx_data     (rx_data),
        .enable      (enable),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .rx_timeout  (rx_timeout),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        rx_avbl_i = 1'b1;
        rx_data   = b;
        tick();
        rx_avbl_i = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
        chk("sb_left", sb.size(), 0);
    endtask

    // Reference model: inputs are stable at the falling edge.
    always @(negedge clk) begin
        int  c0;
        bit  pp;
        if (rst) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            chk("count", fifo_count, m_cnt);
            chk("valid", out_valid, m_cnt != 0);
            if (flush) begin
                sb.delete();
                m_cnt = 0;
            end else begin
                c0 = m_cnt;
                pp = out_valid && out_ready;
                if (pp) begin
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        chk("data", out_data, sb[0]);
                        void'(sb.pop_front());
                        m_cnt--;
                    end
                end
                if (rx_avbl_i && enable && (c0 < FD || pp)) begin
                    sb.push_back(rx_data);
                    m_cnt++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_irq", irq, 0);
        chk("rst_to", rx_timeout, 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of traffic.
        pulse(8'hA1);
        pulse(8'hA2);
        pulse(8'hA3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_count", fifo_count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_irq", irq, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse(8'h5A);
        chk("post_rst_head", out_data, 8'h5A);
        chk("post_rst_cnt", fifo_count, 1);
        drain(1);

        // Ordering and one-cycle latency.
        pulse(8'h11);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 8'h11);
        pulse(8'h22);
        pulse(8'h33);
        chk("cnt3", fifo_count, 3);
        drain(3);
        chk("cnt0", fifo_count, 0);

        // enable=0 ignores words without overrun.
        enable = 1'b0;
        pulse(8'h77);
        chk("dis_cnt", fifo_count, 0);
        chk("dis_ovr", overrun, 0);
        enable = 1'b1;

        // Fill past full, then drop alongside clr_overrun.
        for (int i = 0; i < 9; i++)
            pulse(8'h80 + 8'(i));
        chk("full_cnt", fifo_count, 8);
        chk("ovr_set", overrun, 1);
        clr_overrun = 1'b1;
        pulse(8'h99);
        clr_overrun = 1'b0;
        chk("ovr_win", overrun, 1);
        drain(8);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_irq", irq, 1);

        // flush with simultaneous push; overrun untouched.
        pulse(8'h41);
        pulse(8'h42);
        flush = 1'b1;
        rx_avbl_i = 1'b1;
        rx_data = 8'h43;
        tick();
        flush = 1'b0;
        rx_avbl_i = 1'b0;
        chk("flush_cnt", fifo_count, 0);
        chk("flush_ovr", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clr", overrun, 0);
        chk("ovr_clr_irq", irq, 0);

        // Full with push and pop together.
        for (int i = 0; i < 8; i++)
            pulse(8'hC0 + 8'(i));
        rx_avbl_i = 1'b1;
        rx_data = 8'hEE;
        out_ready = 1'b1;
        tick();
        rx_avbl_i = 1'b0;
        out_ready = 1'b0;
        chk("pp_cnt", fifo_count, 8);
        chk("pp_ovr", overrun, 0);
        drain(8);

        // Threshold interrupt.
        pulse(8'h01);
        pulse(8'h02);
        pulse(8'h03);
        chk("th_below", irq, 0);
        pulse(8'h04);
        chk("th_at", irq, 1);
        chk("th_cnt", fifo_count, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("th_drop", irq, 0);
        drain(3);

`ifdef UART_RX_TIMEOUT_EN
        pulse(8'h5C);
        repeat (TO - 1) tick();
        chk("to_early", rx_timeout, 0);
        tick();
        chk("to_set", rx_timeout, 1);
        chk("to_irq", irq, 1);
        drain(1);
        chk("to_clr", rx_timeout, 0);
        chk("to_clr_irq", irq, 0);
        repeat (TO + 4) tick();
        chk("to_idle", rx_timeout, 0);
        pulse(8'h6D);
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("to_fl_cnt", fifo_count, 0);
        repeat (TO + 4) tick();
        chk("to_fl_none", rx_timeout, 0);
`else
        pulse(8'h5C);
        repeat (TO + 4) tick();
        chk("to_off", rx_timeout, 0);
        chk("to_off_irq", irq, 0);
        drain(1);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller between the UART receiver and the consuming logic.
- Captures each byte the receiver flags with its one-cycle rx_avbl_i pulse into a small FIFO and presents bytes on a valid/ready interface.
- Tracks overrun and raises a level interrupt on fill threshold, overrun or inter-byte idle timeout.
- Sits directly downstream of the receiver's data_read/rx_avbl_i outputs, feeding the host-side controller.

Parameters:
- WORD_SIZE, 8, width of one received word; must match the receiver.
- FIFO_DEPTH, 8, FIFO entries; power of 2, at least 2.
- IRQ_THRESHOLD, 4, FIFO count at or above which irq asserts; range 1..FIFO_DEPTH.
- TIMEOUT_CYCLES, 20000, clk cycles with no push/pop and a non-empty FIFO before the timeout flag sets; at least 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_avbl_i  input  1  one-cycle pulse from the receiver: rx_data holds a valid word
- rx_data  input  WORD_SIZE  word from the receiver; sampled only when rx_avbl_i=1
- enable  input  1  1 = accept incoming words; 0 = ignore rx_avbl_i
- flush  input  1  synchronous FIFO clear
- out_data  output  WORD_SIZE  head-of-FIFO word
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data when out_valid=1
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- overrun  output  1  sticky: a word was dropped because the FIFO was full
- clr_overrun  input  1  clears overrun
- rx_timeout  output  1  idle-timeout flag
- irq  output  1  level interrupt

Behaviour:
- Reset (async, rst=1):
  - pointers, fifo_count, overrun, rx_timeout, irq, out_valid = 0
  - out_data = 0
  - timeout FSM = T_IDLE
  - no write from rx_avbl_i is accepted while rst=1
- Push: push_req = rx_avbl_i & enable.
  - Accept if count < FIFO_DEPTH, or if count = FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise drop the word and set overrun.
- Pop: occurs when out_valid & out_ready.
  - out_data is first-word-fall-through: it equals the head entry whenever out_valid=1, and is don't-care when empty.
- Latency: rx_avbl_i on cycle N means out_valid=1 and out_data=word on cycle N+1 (FIFO previously empty).
- fifo_count: +1 on push only, -1 on pop only, unchanged on push+pop.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Push+pop when empty: not possible (out_valid=0); the push proceeds alone.
- flush=1 on a clock edge:
  - pointers and count go to 0, and the timeout FSM goes to T_IDLE.
  - A push or pop in that same cycle is discarded.
  - overrun is unaffected.
- overrun: set on a dropped word; cleared on clr_overrun. A set in the same cycle as clr_overrun wins (stays 1).
- enable=0: rx_avbl_i is ignored with no overrun. Pops and flush still operate.
- Timeout FSM (registered, updated every clk):
  - T_IDLE: timer=0. Go to T_ARMED when post-update count becomes non-zero.
  - T_ARMED:
    - Timer increments each cycle with no push or pop.
    - Any push or pop resets the timer to 0.
    - If count becomes 0, go to T_IDLE.
    - When the timer reaches TIMEOUT_CYCLES-1, go to T_EXPIRED and set rx_timeout=1.
  - T_EXPIRED: rx_timeout=1. On any push or pop: rx_timeout=0, timer=0, then go to T_ARMED, or to T_IDLE if count becomes 0.
  - Timer width: $clog2(TIMEOUT_CYCLES).
- irq is registered: irq = (count >= IRQ_THRESHOLD) | overrun | rx_timeout, evaluated on next-state values, so it asserts in the same cycle as its causes.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined: timeout FSM and timer are present as specified above.
- Undefined:
  - no timer or FSM is built.
  - rx_timeout is tied to 0.
  - irq = (count >= IRQ_THRESHOLD) | overrun.
  - TIMEOUT_CYCLES is unused.
  - All other behaviour is identical.

Decomposition:
- Shared package (uart_pkg) holds:
  - WORD_SIZE, CLOCK_FREQ, BAUD_RATE, and derived BAUD_LIMIT
  - default FIFO_DEPTH, IRQ_THRESHOLD and TIMEOUT_CYCLES, with the default TIMEOUT_CYCLES expressed as 4*WORD_SIZE*BAUD_LIMIT-scaled in the package
  - timeout FSM state encoding: T_IDLE=0, T_ARMED=1, T_EXPIRED=2
- One sub-module: uart_rx_fifo.
  - Sync FIFO with push/pop/flush, count, full/empty, FWFT head output.
  - uart_rx_ctrl adds the push gating, overrun, timeout FSM and irq.

Test Plan:
1. Reset mid-traffic: push 3 words, assert rst asynchronously between edges -> count, out_valid, overrun, irq read 0 immediately; the next rx_avbl_i lands at FIFO index 0.
2. Ordering and latency: FIFO_DEPTH=8, out_ready=0, push 0x11,0x22,0x33 -> out_valid=1 one cycle after the first pulse, count=3. Then out_ready=1 -> 0x11, 0x22, 0x33 on successive cycles, count=0.
3. Full/overrun: push 9 words with out_ready=0 -> count=8 and overrun=1 after the 9th; the 9th word is absent from the drained data. clr_overrun together with a 10th drop -> overrun stays 1.
4. Full with simultaneous push+pop: count=8, rx_avbl_i=1 and out_ready=1 in the same cycle -> count stays 8, overrun=0, new word appears last in drain order.
5. Threshold irq: IRQ_THRESHOLD=4, push 4 words -> irq=1 in the cycle count=4. Pop 1 -> irq=0 (overrun=0, rx_timeout=0).
6. Timeout (UART_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16): push 1 word, idle -> rx_timeout=1 and irq=1 after 16 idle cycles. One pop -> rx_timeout=0, FSM in T_IDLE. flush during T_ARMED -> count=0, no timeout.
